// File: rtl/render_frame_scheduler.sv
// rtl/render_frame_scheduler.sv - per-frame 3D render pass sequencer with scene snapshot and ping-pong buffer select
// Optional drain watchdog: define RENDER_SCHED_TIMEOUT_EN.
module render_frame_scheduler #(
  parameter int START_X        = 390,
  parameter int END_X          = 634,
  parameter int START_Y        = 390,
  parameter int END_Y          = 765,
  parameter int REGION_DIVIDE  = 530,
  parameter int SCENE_W        = 2112,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               new_frame_in,
  input  logic [SCENE_W-1:0] scene_in,
  output logic [SCENE_W-1:0] scene_out,
  output logic               coord_valid_out,
  input  logic               coord_ready_in,
  output logic [10:0]        hcount_out,
  output logic [9:0]         vcount_out,
  output logic [1:0]         select_objs_out,
  input  logic               pixel_valid_in,
  output logic               wr_buf_out,
  output logic               disp_buf_out,
  output logic               busy_out,
  output logic               dropped_out,
  output logic               error_out
);

  localparam int TOTAL = (END_X - START_X) * (END_Y - START_Y);
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [10:0] H_FIRST = 11'(START_X);
  localparam logic [10:0] H_LAST  = 11'(END_X - 1);
  localparam logic [9:0]  V_FIRST = 10'(START_Y);
  localparam logic [9:0]  V_LAST  = 10'(END_Y - 1);
  localparam logic [9:0]  V_DIV   = 10'(REGION_DIVIDE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [SCENE_W-1:0] r_scene;
  logic [10:0]        r_hcount;
  logic [9:0]         r_vcount;
  logic [1:0]         r_select;
  logic               r_coord_valid;
  logic [CNT_W-1:0]   r_pix_cnt;
  logic               r_wr_buf;
  logic               r_disp_buf;
  logic               r_busy;
  logic               r_dropped;

  logic               w_xfer;
  logic [CNT_W-1:0]   w_pix_cnt_next;
  logic               w_start;

  // Upper rows also contain the pin cylinders; below the divide only the ball can appear.
  function automatic logic [1:0] sel_for(input logic [9:0] v);
    return (v < V_DIV) ? 2'b11 : 2'b10;
  endfunction

  assign w_xfer         = r_coord_valid & coord_ready_in;
  assign w_pix_cnt_next = (pixel_valid_in && (r_pix_cnt != TOTAL_C)) ? r_pix_cnt + CNT_W'(1) : r_pix_cnt;
  assign w_start        = new_frame_in && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef RENDER_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_error;
  logic            w_wd_fire;

  assign w_wd_fire = (r_state == S_DRAIN) && !pixel_valid_in && (r_wd >= WD_LAST)
                     && (w_pix_cnt_next != TOTAL_C);
  assign error_out = r_error;

  // Idle-cycle counter since the last returned pixel; saturates so a long issue stall cannot wrap it.
  always_ff @(posedge clk_in) begin
    if (rst_in || w_start) begin
      r_wd <= '0;
    end else if ((r_state == S_ISSUE) || (r_state == S_DRAIN)) begin
      if (pixel_valid_in) r_wd <= '0;
      else if (r_wd != WD_LAST) r_wd <= r_wd + WD_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_error <= 1'b0;
    else        r_error <= w_wd_fire;
  end
`else
  logic w_wd_fire;
  assign w_wd_fire = 1'b0;
  assign error_out = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_scene       <= '0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_select      <= 2'b00;
      r_coord_valid <= 1'b0;
      r_pix_cnt     <= '0;
      r_wr_buf      <= 1'b0;
      r_disp_buf    <= 1'b1;
      r_busy        <= 1'b0;
      r_dropped     <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (new_frame_in) begin
            // Swap only after a completed pass; a start from IDLE keeps the buffers as they are.
            if (r_state == S_DONE) begin
              r_disp_buf <= r_wr_buf;
              r_wr_buf   <= ~r_wr_buf;
            end
            r_scene       <= scene_in;
            r_hcount      <= H_FIRST;
            r_vcount      <= V_FIRST;
            r_select      <= sel_for(V_FIRST);
            r_coord_valid <= 1'b1;
            r_pix_cnt     <= '0;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_pix_cnt <= w_pix_cnt_next;
          r_dropped <= new_frame_in;
          if (w_xfer) begin
            if (r_hcount == H_LAST) begin
              r_hcount <= H_FIRST;
              if (r_vcount == V_LAST) begin
                r_vcount      <= V_FIRST;
                r_select      <= sel_for(V_FIRST);
                r_coord_valid <= 1'b0;
                r_state       <= S_DRAIN;
              end else begin
                r_vcount <= r_vcount + 10'd1;
                r_select <= sel_for(r_vcount + 10'd1);
              end
            end else begin
              r_hcount <= r_hcount + 11'd1;
            end
          end
        end
        S_DRAIN: begin
          r_pix_cnt <= w_pix_cnt_next;
          r_dropped <= new_frame_in;
          if (w_pix_cnt_next == TOTAL_C) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else if (w_wd_fire) begin
            r_busy    <= 1'b0;
            r_pix_cnt <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign scene_out       = r_scene;
  assign coord_valid_out = r_coord_valid;
  assign hcount_out      = r_hcount;
  assign vcount_out      = r_vcount;
  assign select_objs_out = r_select;
  assign wr_buf_out      = r_wr_buf;
  assign disp_buf_out    = r_disp_buf;
  assign busy_out        = r_busy;
  assign dropped_out     = r_dropped;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// tb/tb_render_frame_scheduler.sv - scoreboard bench for render_frame_scheduler with randomized ready and pixel echo
module tb_render_frame_scheduler;
  localparam int SX = 0, EX = 4, SY = 0, EY = 3, RD = 1, TO = 16, SW = 2112;
  localparam int TOTAL = (EX - SX) * (EY - SY);
  localparam int P_IDLE = 0, P_PASS = 1, P_DONE = 2;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          new_frame_in = 1'b0;
  logic [SW-1:0] scene_in = '0;
  logic [SW-1:0] scene_out;
  logic          coord_valid_out;
  logic          coord_ready_in = 1'b0;
  logic [10:0]   hcount_out;
  logic [9:0]    vcount_out;
  logic [1:0]    select_objs_out;
  logic          pixel_valid_in = 1'b0;
  logic          wr_buf_out, disp_buf_out, busy_out, dropped_out, error_out;

  render_frame_scheduler #(
    .START_X(SX), .END_X(EX), .START_Y(SY), .END_Y(EY),
    .REGION_DIVIDE(RD), .SCENE_W(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .new_frame_in(new_frame_in),
    .scene_in(scene_in), .scene_out(scene_out),
    .coord_valid_out(coord_valid_out), .coord_ready_in(coord_ready_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .select_objs_out(select_objs_out),
    .pixel_valid_in(pixel_valid_in), .wr_buf_out(wr_buf_out), .disp_buf_out(disp_buf_out),
    .busy_out(busy_out), .dropped_out(dropped_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int x; int y; int sel; } coord_t;
  coord_t exp_q[$];

  int            m_phase = P_IDLE;
  int            m_issued = 0, m_cnt = 0, m_wd = 0;
  bit            m_wr = 0, m_disp = 1, m_drop = 0, m_err = 0, m_zero = 1;
  logic [SW-1:0] m_scene = '0;

  int n_pass = 0, n_total = 0;
  bit mon_en = 0;

  bit rand_ready = 0, nf_req = 0, rst_req = 0;
  int echo_left = 0, bogus_left = 0;
  bit [2:0] pipe = 3'b000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [SW-1:0] rand_scene();
    logic [SW-1:0] s;
    for (int i = 0; i < SW / 32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  // Reference model: one frame pass = all window coords row-major, done when every coord is out and TOTAL pixels are back.
  task automatic model_edge(input bit r, input bit nf, input bit pv, input bit x);
    bit all_prior;
    m_drop = 0;
    m_err  = 0;
    if (r) begin
      m_phase = P_IDLE; m_issued = 0; m_cnt = 0; m_wd = 0;
      m_wr = 0; m_disp = 1; m_zero = 1; m_scene = '0;
      exp_q.delete();
      return;
    end
    if (m_phase == P_IDLE || m_phase == P_DONE) begin
      if (nf) begin
        if (m_phase == P_DONE) begin m_disp = m_wr; m_wr = !m_wr; end
        m_scene = scene_in; m_phase = P_PASS; m_issued = 0; m_cnt = 0; m_wd = 0; m_zero = 0;
        exp_q.delete();
        for (int y = SY; y < EY; y++)
          for (int xx = SX; xx < EX; xx++)
            exp_q.push_back('{x: xx, y: y, sel: (y < RD) ? 3 : 2});
      end
    end else begin
      m_drop = nf;
      all_prior = (m_issued == TOTAL);
      if (x) m_issued++;
      if (pv && m_cnt < TOTAL) m_cnt++;
      if (all_prior && m_cnt == TOTAL) m_phase = P_DONE;
`ifdef RENDER_SCHED_TIMEOUT_EN
      else if (all_prior && !pv && m_wd >= TO - 1) begin m_err = 1; m_phase = P_IDLE; end
`endif
      m_wd = pv ? 0 : ((m_wd < TO - 1) ? m_wd + 1 : m_wd);
    end
  endtask

  task automatic step();
    bit x, pvv;
    rst_in = rst_req; new_frame_in = nf_req;
    rst_req = 0; nf_req = 0;
    scene_in = rand_scene();
    coord_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    pvv = pipe[2] && (echo_left > 0);
    if (pvv) echo_left--;
    if (bogus_left > 0) begin pvv = 1; bogus_left--; end
    pixel_valid_in = pvv;
    x = coord_valid_out && coord_ready_in;
    pipe = {pipe[1:0], x};
    @(posedge clk_in);
    model_edge(rst_in, new_frame_in, pvv, x);
    #1;
  endtask

  task automatic run_until(input string nm, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_phase == target) break;
      step();
    end
    chk(nm, {63'd0, busy_out}, {63'd0, target == P_PASS});
  endtask

  initial begin : monitor
    coord_t c;
    forever begin
      @(negedge clk_in);
      if (mon_en) begin
        chk("coord_valid", coord_valid_out, (m_phase == P_PASS) && (m_issued < TOTAL));
        if (coord_valid_out) begin
          if (exp_q.size() == 0) chk("coord_extra", 1, 0);
          else begin
            c = exp_q[0];
            chk("hcount", hcount_out, c.x);
            chk("vcount", vcount_out, c.y);
            chk("select", select_objs_out, c.sel);
            if (coord_ready_in) void'(exp_q.pop_front());
          end
        end
        if (m_zero) begin
          chk("rst_hcount", hcount_out, 0);
          chk("rst_vcount", vcount_out, 0);
          chk("rst_select", select_objs_out, 0);
        end
        chk("busy", busy_out, m_phase == P_PASS);
        chk("wr_buf", wr_buf_out, m_wr);
        chk("disp_buf", disp_buf_out, m_disp);
        chk("dropped", dropped_out, m_drop);
        chk("error", error_out, m_err);
        n_total++;
        if (scene_out === m_scene) n_pass++;
        else $display("FAIL scene: got low %0h expected low %0h at %0t", scene_out[63:0], m_scene[63:0], $time);
      end
    end
  end

  initial begin : driver
    rst_req = 1; step();
    rst_req = 1; step();
    mon_en = 1;
    repeat (3) step();
    bogus_left = 5;
    repeat (8) step();

    echo_left = 1000; rand_ready = 0; nf_req = 1; step();
    run_until("pass1_done", P_DONE, 100);
    bogus_left = 4;
    repeat (6) step();

    rand_ready = 1; nf_req = 1; step();
    for (int i = 0; i < 200 && m_issued < 5; i++) step();
    nf_req = 1; step();
    run_until("pass2_done", P_DONE, 200);
    repeat (3) step();

    nf_req = 1; bogus_left = 15; step();
    run_until("pass3_done", P_DONE, 200);
    repeat (4) step();

    nf_req = 1; step(); step(); step();
    rst_req = 1; step();
    repeat (4) step();

    echo_left = 7; nf_req = 1; step();
    for (int i = 0; i < 80; i++) begin
      if (m_phase != P_PASS) break;
      step();
    end
`ifdef RENDER_SCHED_TIMEOUT_EN
    chk("drain_wait", busy_out, 0);
`else
    chk("drain_wait", busy_out, 1);
`endif
    rst_req = 1; step();
    repeat (2) step();

    echo_left = 1000; rand_ready = 1; nf_req = 1; step();
    run_until("pass4_done", P_DONE, 200);
    nf_req = 1; step();
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
